// File: rtl/trap_causes.sv
// rtl/trap_causes.sv - synchronous exception cause codes shared across the core
package trap_causes;

  typedef enum logic [4:0] {
    EXC_INSTR_MISALIGNED = 5'd0,
    EXC_INSTR_ACCESS     = 5'd1,
    EXC_ILLEGAL_INSTR    = 5'd2,
    EXC_BREAKPOINT       = 5'd3,
    EXC_LOAD_MISALIGNED  = 5'd4,
    EXC_LOAD_ACCESS      = 5'd5,
    EXC_STORE_MISALIGNED = 5'd6,
    EXC_STORE_ACCESS     = 5'd7,
    EXC_ECALL_M          = 5'd11
  } trap_cause_e;

endpackage

// File: rtl/trap_pkg.sv
// rtl/trap_pkg.sv - trap CSR addresses, operation/mode encodings and helpers
package trap_pkg;
  import trap_causes::*;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam int IRQ_CAUSE_BASE   = 16;
  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    MTVEC_DIRECT   = 2'b00,
    MTVEC_VECTORED = 2'b01
  } mtvec_mode_e;

  function automatic logic csr_is_readonly(input logic [11:0] addr);
    return (addr >= CSR_MVENDORID) && (addr <= CSR_MHARTID);
  endfunction

endpackage

// File: rtl/irq_sync.sv
// rtl/irq_sync.sv - two-flop irq synchroniser with lowest-index pending encoder
module irq_sync
  import trap_pkg::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] mask_i,
  output logic [NUM_IRQ-1:0] level_o,
  output logic               valid_o,
  output logic [3:0]         index_o
);

  logic [NUM_IRQ-1:0] meta_q;
  logic [NUM_IRQ-1:0] sync_q;
  logic [NUM_IRQ-1:0] pend;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= irq_i;
      sync_q <= meta_q;
    end
  end

  assign level_o = sync_q;
  assign pend    = sync_q & mask_i;

  // Scan downwards so the lowest pending index is the last one written.
  always_comb begin
    valid_o = 1'b0;
    index_o = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend[i]) begin
        valid_o = 1'b1;
        index_o = 4'(i);
      end
    end
  end

endmodule

// File: rtl/trap_csr_unit.sv
// rtl/trap_csr_unit.sv - machine-mode trap controller, trap CSR file and fetch redirect
module trap_csr_unit
  import trap_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              NUM_IRQ     = 4,
  parameter bit              VECTORED_EN = 1'b1,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               exc_valid,
  input  logic [4:0]         exc_cause,
  input  logic [XLEN-1:0]    exc_tval,
  input  logic [XLEN-1:0]    exc_pc,
  input  logic [XLEN-1:0]    retire_pc,
  input  logic               mret_valid,
  input  logic               csr_valid,
  input  logic               csr_write,
  input  logic [1:0]         csr_op,
  input  logic [11:0]        csr_addr,
  input  logic [XLEN-1:0]    csr_wdata,
  output logic [XLEN-1:0]    csr_rdata,
  output logic               csr_illegal,
  output logic               redirect_valid,
  output logic [XLEN-1:0]    redirect_pc,
  output logic               irq_taken
);

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_REDIRECT = 1'b1;
  localparam logic [XLEN-1:0] IRQ_MASK =
      XLEN'(((64'd1 << NUM_IRQ) - 64'd1) << IRQ_CAUSE_BASE);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic [0:0]      state_q, state_d;
  logic            mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
  logic [XLEN-1:0] mie_q, mie_d, mtvec_q, mtvec_d, mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d, mtval_q, mtval_d;
  logic            redirect_valid_q, redirect_valid_d, irq_taken_q, irq_taken_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

  logic [NUM_IRQ-1:0] irq_level;
  logic               irq_pend;
  logic [3:0]         irq_index;
  logic [XLEN-1:0]    old_val, new_val, tvec_base, irq_code;
  logic               addr_known, csr_we;

  irq_sync #(.NUM_IRQ(NUM_IRQ)) u_irq_sync (
    .clk_i   (clk),
    .rst_ni  (rst),
    .irq_i   (irq),
    .mask_i  (mie_q[IRQ_CAUSE_BASE +: NUM_IRQ]),
    .level_o (irq_level),
    .valid_o (irq_pend),
    .index_o (irq_index)
  );

  always_comb begin
    old_val    = '0;
    addr_known = 1'b1;
    case (csr_addr)
      CSR_MSTATUS: begin
        old_val[MSTATUS_MIE_BIT]  = mst_mie_q;
        old_val[MSTATUS_MPIE_BIT] = mst_mpie_q;
      end
      CSR_MIE:    old_val = mie_q;
      CSR_MTVEC:  old_val = mtvec_q;
      CSR_MEPC:   old_val = mepc_q;
      CSR_MCAUSE: old_val = mcause_q;
      CSR_MTVAL:  old_val = mtval_q;
      CSR_MIP:    old_val[IRQ_CAUSE_BASE +: NUM_IRQ] = irq_level;
      CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID, CSR_MHARTID: old_val = '0;
      default:    addr_known = 1'b0;
    endcase
  end

  assign csr_rdata   = old_val;
  assign csr_illegal = csr_valid && (!addr_known || (csr_write && csr_is_readonly(csr_addr)));

  always_comb begin
    case (csr_op)
      CSR_OP_RW: new_val = csr_wdata;
      CSR_OP_RS: new_val = old_val | csr_wdata;
      CSR_OP_RC: new_val = old_val & ~csr_wdata;
      default:   new_val = old_val;
    endcase
  end

  assign tvec_base = mtvec_q & ALIGN_MASK;
  assign irq_code  = XLEN'(IRQ_CAUSE_BASE) + XLEN'(irq_index);

  // Trap/MRET assignments come after the CSR write so they win on overlapping fields.
  always_comb begin
    state_d          = ST_IDLE;
    mst_mie_d        = mst_mie_q;
    mst_mpie_d       = mst_mpie_q;
    mie_d            = mie_q;
    mtvec_d          = mtvec_q;
    mepc_d           = mepc_q;
    mcause_d         = mcause_q;
    mtval_d          = mtval_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    irq_taken_d      = 1'b0;
    csr_we           = 1'b0;
    if (state_q == ST_IDLE) begin
      csr_we = csr_valid && csr_write && !csr_illegal && !exc_valid;
      if (csr_we) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            mst_mie_d  = new_val[MSTATUS_MIE_BIT];
            mst_mpie_d = new_val[MSTATUS_MPIE_BIT];
          end
          CSR_MIE:    mie_d = new_val & IRQ_MASK;
          CSR_MTVEC:  mtvec_d = {new_val[XLEN-1:2],
                                 (VECTORED_EN && new_val[1:0] == MTVEC_VECTORED) ?
                                 MTVEC_VECTORED : MTVEC_DIRECT};
          CSR_MEPC:   mepc_d = new_val & ALIGN_MASK;
          CSR_MCAUSE: mcause_d = new_val;
          CSR_MTVAL:  mtval_d = new_val;
          default: ;
        endcase
      end
      if (exc_valid) begin
        mepc_d           = exc_pc & ALIGN_MASK;
        mcause_d         = XLEN'(exc_cause);
        mtval_d          = exc_tval;
        mst_mpie_d       = mst_mie_q;
        mst_mie_d        = 1'b0;
        redirect_pc_d    = tvec_base;
        redirect_valid_d = 1'b1;
      end else if (mst_mie_q && irq_pend) begin
        mepc_d           = retire_pc;
        mcause_d         = irq_code | {1'b1, {(XLEN-1){1'b0}}};
        mtval_d          = '0;
        mst_mpie_d       = mst_mie_q;
        mst_mie_d        = 1'b0;
        redirect_pc_d    = (mtvec_q[1:0] == MTVEC_VECTORED) ? tvec_base + (irq_code << 2) : tvec_base;
        redirect_valid_d = 1'b1;
        irq_taken_d      = 1'b1;
      end else if (mret_valid) begin
        mst_mie_d        = mst_mpie_q;
        mst_mpie_d       = 1'b1;
        redirect_pc_d    = mepc_q;
        redirect_valid_d = 1'b1;
      end
      if (redirect_valid_d) state_d = ST_REDIRECT;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= ST_IDLE;
      mst_mie_q        <= 1'b0;
      mst_mpie_q       <= 1'b0;
      mie_q            <= '0;
      mtvec_q          <= MTVEC_RESET;
      mepc_q           <= '0;
      mcause_q         <= '0;
      mtval_q          <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      irq_taken_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      mst_mie_q        <= mst_mie_d;
      mst_mpie_q       <= mst_mpie_d;
      mie_q            <= mie_d;
      mtvec_q          <= mtvec_d;
      mepc_q           <= mepc_d;
      mcause_q         <= mcause_d;
      mtval_q          <= mtval_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      irq_taken_q      <= irq_taken_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign irq_taken      = irq_taken_q;

endmodule
